byte_to_word: RTL and testbench
===============================

# byte_to_word

Receive-side width converter that rebuilds 32-bit words from a byte stream for the two-lane unstriping multiplexer. It runs on the 4x clock and locks onto the link only after a run of idle COM characters. It then packs four consecutive valid bytes, MSB first, into one 32-bit word. Each output word is held for four clk_4f cycles, so data_out/valid_out present one word per clk_f period to the downstream lane input of the unstriping mux.

## Interface
- COM_CHAR, default 8'hBC: idle/comma byte sent while valid_in=0.
- BC_COUNT, default 4: consecutive COM_CHAR bytes needed to go active; range 1..15.

- clk_4f  input  1  sole clock; all logic on posedge.
- reset_L  input  1  synchronous, active-low reset; sampled on posedge clk_4f.
- data_in  input  8  byte from the upstream byte stream.
- valid_in  input  1  data_in carries payload; 0 means idle (COM_CHAR expected).
- data_out  output  32  assembled word, {b0,b1,b2,b3}, b0 = first byte received.
- valid_out  output  1  data_out holds a complete word.
- active_out  output  1  link synchronised; words are being assembled.
- error_out  output  1  idle byte not equal to COM_CHAR (only with COM_CHECK_EN).

## Operation
- Reset (reset_L=0 at posedge): state=INIT, data_out=32'h0, valid_out=0, active_out=0, error_out=0, and all counters=0.
- FSM INIT:
  - Count consecutive samples with valid_in=0 and data_in==COM_CHAR.
  - Any other sample clears the count. valid_in=1 bytes are discarded.
  - On the edge the count reaches BC_COUNT, go to ACTIVE and set active_out=1.
- FSM ACTIVE: leaves only on reset.
- Packing in ACTIVE:
  - Byte index 0..3 advances on each valid_in=1 sample; the byte goes to lane position 3-index (bits [31:24] first).
  - At the 4th valid byte, load data_out with the full word, set valid_out=1, wrap the index to 0, and restart the 4-cycle hold counter.
- Partial word: a valid_in=0 sample with index 1..3 discards the collected bytes and sets the index to 0. data_out and valid_out are unaffected.
- Hold: valid_out drops on the 4th edge after a load unless a new load occurs on that same edge. Back-to-back words keep valid_out=1 continuously. data_out keeps its last value while valid_out=0.
- Bytes sampled in INIT, including the BC_COUNT-th COM byte, never enter a word.
- Reset mid-word or mid-hold: the next edge with reset_L=0 forces reset values. The partial word is lost, and BC_COUNT COM bytes are required again.

## Timing
- Latency: the last byte of a word is sampled at edge k; data_out and valid_out change at edge k (visible after k).
- The first word's earliest byte is sampled at the edge after active_out rises.
- The word rate is at most one per 4 edges, i.e. the clk_f rate. The downstream stage samples on clk_f with the hold window aligned to the 4th byte.
- active_out rises on the edge sampling the BC_COUNT-th consecutive COM byte.
- error_out is registered: it is 1 for the cycle after a bad idle byte is sampled and clears on the next good sample.

## Configuration
- COM_CHECK_EN defined:
  - In ACTIVE, every valid_in=0 sample with data_in!=COM_CHAR sets error_out=1 for one cycle.
  - The check also applies to the sample that aborts a partial word.
  - error_out has no effect on the FSM or on packing.
- COM_CHECK_EN undefined: error_out is tied to 0 and no comparison logic is built. The INIT COM counting is unaffected.

## Test plan
- Sync: after reset, send 4x (valid_in=0, 8'hBC) -> active_out=1 on the 4th edge. Sending 3x 8'hBC, then 8'h00, then 4x 8'hBC -> active_out rises only on the final 8'hBC.
- Single word: in ACTIVE, send valid bytes EE,EE,EE,EE -> data_out=32'hEEEEEEEE and valid_out=1 for exactly 4 edges, then valid_out=0 with data_out held.
- Back-to-back: send EE,EE,EE,E0 then EE,EE,EE,E1 contiguously -> data_out=32'hEEEEEEE0 then 32'hEEEEEEE1, with valid_out continuously 1 for 8 edges.
- Partial abort: send AA,BB, then idle BC, then 11,22,33,44 -> no word AABB...; data_out=32'h11223344 only.
- Reset mid-word: send 12,34, assert reset_L=0 for 1 cycle, then send bytes without the BC preamble -> all outputs 0 and active_out stays 0 until 4 BCs are received.
- With COM_CHECK_EN: in ACTIVE send an idle byte 8'h5A -> error_out=1 for one cycle. Subsequent word 32'hCAFE0001 is still assembled correctly.

Source files
------------

// File: rtl/byte_to_word.sv
// -----------------------------------------------------------------------------
// byte_to_word
//
// Receive-side width converter for the two-lane unstriping multiplexer. It
// runs on the 4x clock (clk_4f). The block stays in INIT until it has seen
// BC_COUNT consecutive idle COM characters. It then goes ACTIVE and packs
// every four consecutive valid bytes, MSB first, into one 32-bit word.
// Each word is held on data_out/valid_out for four clk_4f edges, so the
// downstream lane input that samples on clk_f sees one word per period.
//
// Parameters
//   COM_CHAR  idle/comma byte expected while valid_in=0 (default 8'hBC)
//   BC_COUNT  consecutive COM bytes needed to go active, 1..15 (default 4)
//
// Optional feature macro
//   COM_CHECK_EN  when defined, flags idle bytes that are not COM_CHAR while
//                 ACTIVE on error_out; when undefined, error_out is tied to 0
//
// Ports
//   clk_4f      in   1   sole clock, all logic on posedge
//   reset_L     in   1   synchronous active-low reset
//   data_in     in   8   byte from the upstream byte stream
//   valid_in    in   1   data_in carries payload (0 = idle)
//   data_out    out  32  assembled word {b0,b1,b2,b3}, b0 received first
//   valid_out   out  1   data_out holds a complete word
//   active_out  out  1   link synchronised, words are being assembled
//   error_out   out  1   idle byte was not COM_CHAR (COM_CHECK_EN only)
// -----------------------------------------------------------------------------
module byte_to_word #(
    parameter logic [7:0] COM_CHAR = 8'hBC,
    parameter int          BC_COUNT = 4
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active_out,
    output logic        error_out
);

    typedef enum logic {S_INIT = 1'b0, S_ACTIVE = 1'b1} state_t;

    localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  bc_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] acc_p0;     // first three bytes of the word being built
    logic [1:0]  hold_cnt;   // edges elapsed since the last word load
    logic        is_com;
    logic        bc_done;

    assign is_com  = !valid_in && (data_in == COM_CHAR);
    // True on the sample that completes the required run of COM bytes.
    assign bc_done = is_com && ((bc_cnt + 4'd1) == BC_LIM);

    // State register
    always_ff @(posedge clk_4f) begin
        if (!reset_L) state <= S_INIT;
        else          state <= state_nxt;
    end

    // Next-state logic: ACTIVE is left only through reset
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && bc_done) state_nxt = S_ACTIVE;
    end

    // Output logic
    always_comb begin
        active_out = (state == S_ACTIVE);
    end

    // Consecutive COM counter, only meaningful while in INIT
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            bc_cnt <= 4'd0;
        end else if (state == S_INIT) begin
            bc_cnt <= is_com ? bc_cnt + 4'd1 : 4'd0;
        end
    end

    // Byte packing and word hold
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            byte_idx  <= 2'd0;
            acc_p0    <= 24'd0;
            data_out  <= 32'd0;
            valid_out <= 1'b0;
            hold_cnt  <= 2'd0;
        end else begin
            // Hold expiry; a load on this same edge overrides it below.
            if (valid_out) begin
                if (hold_cnt == 2'd3) valid_out <= 1'b0;
                else                  hold_cnt  <= hold_cnt + 2'd1;
            end
            if (state == S_ACTIVE) begin
                if (valid_in) begin
                    if (byte_idx == 2'd3) begin
                        data_out  <= {acc_p0, data_in};
                        valid_out <= 1'b1;
                        hold_cnt  <= 2'd0;
                        byte_idx  <= 2'd0;
                    end else begin
                        case (byte_idx)
                            2'd0:    acc_p0[23:16] <= data_in;
                            2'd1:    acc_p0[15:8]  <= data_in;
                            default: acc_p0[7:0]   <= data_in;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end else begin
                    // An idle sample abandons any partially collected word.
                    byte_idx <= 2'd0;
                end
            end
        end
    end

`ifdef COM_CHECK_EN
    // Registered idle-byte check; one cycle per bad sample, never gates the FSM.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) error_out <= 1'b0;
        else          error_out <= (state == S_ACTIVE) && !valid_in &&
                                   (data_in != COM_CHAR);
    end
`else
    assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_byte_to_word.sv
module tb_byte_to_word;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         BC  = 4;

    logic        clk_4f = 1'b0;
    logic        reset_L = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = COM;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active_out;
    logic        error_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (behavioural, sample by sample)
    bit          m_act;
    int          m_cnt;
    logic [7:0]  m_q[$];
    logic [31:0] m_word;
    int          m_since;   // edges since the last word load
    bit          m_err;

    always #5 clk_4f = ~clk_4f;

    byte_to_word #(.COM_CHAR(COM), .BC_COUNT(BC)) dut (
        .clk_4f     (clk_4f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active_out (active_out),
        .error_out  (error_out)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input logic rl, input logic v, input logic [7:0] d);
        if (!rl) begin
            m_act = 0; m_cnt = 0; m_q.delete(); m_word = 32'h0; m_since = 100; m_err = 0;
        end else if (!m_act) begin
            m_err = 0;
            if (m_since < 100) m_since++;
            if (!v && d == COM) begin
                m_cnt++;
                if (m_cnt == BC) m_act = 1;
            end else begin
                m_cnt = 0;
            end
        end else begin
`ifdef COM_CHECK_EN
            m_err = (!v && d != COM);
`else
            m_err = 0;
`endif
            if (m_since < 100) m_since++;
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    m_word  = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    m_since = 0;
                    m_q.delete();
                end
            end else begin
                m_q.delete();
            end
        end
    endtask

    task automatic tick(input logic rl, input logic v, input logic [7:0] d);
        @(negedge clk_4f);
        reset_L = rl; valid_in = v; data_in = d;
        @(posedge clk_4f);
        model_step(rl, v, d);
        #1;
        check_val("data_out",   data_out,          m_word);
        check_val("valid_out",  {31'd0, valid_out},  {31'd0, m_since < 4});
        check_val("active_out", {31'd0, active_out}, {31'd0, m_act});
        check_val("error_out",  {31'd0, error_out},  {31'd0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, COM);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tick(1'b1, 1'b1, w[8*i +: 8]);
    endtask

    task automatic sync_link();
        tick(1'b0, 1'b0, COM);
        idle(BC);
    endtask

    initial begin
        // Reset state
        tick(1'b0, 1'b0, COM);
        check_val("rst_data",   data_out, 32'h0);
        check_val("rst_active", {31'd0, active_out}, 32'd0);

        // Sync: active rises on the 4th BC
        idle(3);
        check_val("sync_pre", {31'd0, active_out}, 32'd0);
        idle(1);
        check_val("sync_on", {31'd0, active_out}, 32'd1);

        // Sync interrupted by a non-COM idle byte
        tick(1'b0, 1'b0, COM);
        idle(3);
        tick(1'b1, 1'b0, 8'h00);
        idle(3);
        check_val("sync_broken", {31'd0, active_out}, 32'd0);
        idle(1);
        check_val("sync_resumed", {31'd0, active_out}, 32'd1);

        // Single word held for exactly 4 edges
        send_word(32'hEEEEEEEE);
        check_val("single_word", data_out, 32'hEEEEEEEE);
        idle(3);
        check_val("single_hold", {31'd0, valid_out}, 32'd1);
        idle(1);
        check_val("single_drop", {31'd0, valid_out}, 32'd0);
        check_val("single_keep", data_out, 32'hEEEEEEEE);

        // Back-to-back words
        send_word(32'hEEEEEEE0);
        check_val("b2b_w0", data_out, 32'hEEEEEEE0);
        send_word(32'hEEEEEEE1);
        check_val("b2b_w1", data_out, 32'hEEEEEEE1);
        idle(4);

        // Partial abort
        tick(1'b1, 1'b1, 8'hAA);
        tick(1'b1, 1'b1, 8'hBB);
        idle(1);
        send_word(32'h11223344);
        check_val("partial", data_out, 32'h11223344);
        idle(4);

        // Reset mid-word, then bytes without preamble
        tick(1'b1, 1'b1, 8'h12);
        tick(1'b1, 1'b1, 8'h34);
        tick(1'b0, 1'b0, COM);
        send_word(32'h55667788);
        check_val("rst_mid_data",   data_out, 32'h0);
        check_val("rst_mid_active", {31'd0, active_out}, 32'd0);
        idle(4);
        check_val("rst_mid_resync", {31'd0, active_out}, 32'd1);

        // Bad idle byte, then a normal word
        tick(1'b1, 1'b0, 8'h5A);
`ifdef COM_CHECK_EN
        check_val("err_set", {31'd0, error_out}, 32'd1);
`else
        check_val("err_tied", {31'd0, error_out}, 32'd0);
`endif
        send_word(32'hCAFE0001);
        check_val("after_err", data_out, 32'hCAFE0001);
        check_val("err_clear", {31'd0, error_out}, 32'd0);

        // Randomized traffic against the model
        sync_link();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic v;
            logic [7:0] d;
            r = int'($urandom_range(0, 99));
            v = (r < 70);
            if (v) d = 8'($urandom);
            else   d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : COM;
            if ($urandom_range(0, 199) == 0) tick(1'b0, v, d);
            else                             tick(1'b1, v, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
